// File: rtl/mem_arb_pkg.sv
// Shared types for the memory data-port arbiter: bus owner encoding and requester id.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_0    = 2'd1,
    OWN_1    = 2'd2
  } owner_e;

  // 0 = CPU data path, 1 = secondary bus master
  typedef logic req_id_t;

endpackage

// File: rtl/read_tag_pipe.sv
// Fixed-depth shift register of {valid, id} tags that tracks reads in flight to memory.
module read_tag_pipe
  import mem_arb_pkg::*;
#(
  parameter int unsigned Depth = 1
) (
  input  logic    clk,
  input  logic    reset,
  input  logic    push,
  input  req_id_t push_id,
  output logic    pop_valid,
  output req_id_t pop_id
);

  logic    [Depth-1:0] valid_q;
  req_id_t             id_q [Depth];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
      for (int i = 0; i < Depth; i++) begin
        id_q[i] <= 1'b0;
      end
    end else begin
      valid_q[0] <= push;
      id_q[0]    <= push_id;
      for (int i = 1; i < Depth; i++) begin
        valid_q[i] <= valid_q[i-1];
        id_q[i]    <= id_q[i-1];
      end
    end
  end

  assign pop_valid = valid_q[Depth-1];
  assign pop_id    = id_q[Depth-1];

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares memController's data port between two masters: burst tenures with round-robin
// fairness, one access per cycle, read data steered back by a tag pipe.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W    = 15,
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned READ_LAT  = 1,
  parameter int unsigned MAX_BURST = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int unsigned     CntW     = $clog2(MAX_BURST + 1);
  localparam logic [CntW-1:0] BurstMax = CntW'(MAX_BURST);

  owner_e          owner_q, owner_d, other;
  logic            last_q, last_d;
  logic [CntW-1:0] burst_cnt_q, burst_cnt_d, burst_inc;
  logic            acc0, acc1, accept, own_req, oth_req, burst_full;
  logic            read_push, pop_valid;
  req_id_t         pop_id;
  logic [DATA_W-1:0] rdata0_q, rdata1_q;

  assign acc0   = m0_gnt & m0_req;
  assign acc1   = m1_gnt & m1_req;
  assign accept = acc0 | acc1;

  // Saturates at MAX_BURST: an unlimited lone tenure must still yield once the other asks.
  assign burst_inc  = (burst_cnt_q == BurstMax) ? burst_cnt_q : burst_cnt_q + CntW'(accept);
  assign burst_full = (burst_inc >= BurstMax);

  always_comb begin
    own_req = (owner_q == OWN_1) ? m1_req : m0_req;
    oth_req = (owner_q == OWN_1) ? m0_req : m1_req;
    other   = (owner_q == OWN_1) ? OWN_0 : OWN_1;
    owner_d = OWN_NONE;
    if (enable) begin
      if (owner_q == OWN_NONE) begin
        if (m0_req && m1_req) owner_d = last_q ? OWN_0 : OWN_1;
        else if (m0_req)      owner_d = OWN_0;
        else if (m1_req)      owner_d = OWN_1;
      end else if (own_req && (!oth_req || !burst_full)) begin
        owner_d = owner_q;
      end else if (oth_req) begin
        owner_d = other;
      end
    end
  end

  always_comb begin
    burst_cnt_d = (owner_d != owner_q) ? '0 : burst_inc;
    last_d      = last_q;
    if (owner_d == OWN_0) last_d = 1'b0;
    if (owner_d == OWN_1) last_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner_q     <= OWN_NONE;
      last_q      <= 1'b1;
      burst_cnt_q <= '0;
      m0_gnt      <= 1'b0;
      m1_gnt      <= 1'b0;
    end else begin
      owner_q     <= owner_d;
      last_q      <= last_d;
      burst_cnt_q <= burst_cnt_d;
      m0_gnt      <= (owner_d == OWN_0);
      m1_gnt      <= (owner_d == OWN_1);
    end
  end

  assign mem_addr  = (owner_q == OWN_1) ? m1_addr : m0_addr;
  assign mem_wdata = (owner_q == OWN_1) ? m1_wdata : m0_wdata;
  assign mem_we    = (acc0 & m0_we) | (acc1 & m1_we);

  assign read_push = (acc0 & ~m0_we) | (acc1 & ~m1_we);

  read_tag_pipe #(
    .Depth (READ_LAT)
  ) u_read_tag_pipe (
    .clk       (clk),
    .reset     (reset),
    .push      (read_push),
    .push_id   (acc1),
    .pop_valid (pop_valid),
    .pop_id    (pop_id)
  );

  assign m0_rvalid = pop_valid & (pop_id == 1'b0);
  assign m1_rvalid = pop_valid & (pop_id == 1'b1);

  // Memory data is valid in the strobe cycle itself; the hold registers keep it afterwards.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      if (m0_rvalid) rdata0_q <= mem_rdata;
      if (m1_rvalid) rdata1_q <= mem_rdata;
    end
  end

  assign m0_rdata = m0_rvalid ? mem_rdata : rdata0_q;
  assign m1_rdata = m1_rvalid ? mem_rdata : rdata1_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus randomized traffic against a
// transaction-level model of ownership, memory contents and read returns.
module tb_mem_port_arbiter;

  localparam int ADDR_W    = 15;
  localparam int DATA_W    = 16;
  localparam int READ_LAT  = 1;
  localparam int MAX_BURST = 8;

  logic clk = 1'b0;
  logic reset, enable;
  logic [1:0] req, we;
  logic [ADDR_W-1:0] addr [2];
  logic [DATA_W-1:0] wdata [2];
  logic m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, mem_we;
  logic [DATA_W-1:0] m0_rdata, m1_rdata, mem_wdata, mem_rdata;
  logic [ADDR_W-1:0] mem_addr;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .READ_LAT  (READ_LAT),
    .MAX_BURST (MAX_BURST)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .m0_req    (req[0]),
    .m0_we     (we[0]),
    .m0_addr   (addr[0]),
    .m0_wdata  (wdata[0]),
    .m0_gnt    (m0_gnt),
    .m0_rvalid (m0_rvalid),
    .m0_rdata  (m0_rdata),
    .m1_req    (req[1]),
    .m1_we     (we[1]),
    .m1_addr   (addr[1]),
    .m1_wdata  (wdata[1]),
    .m1_gnt    (m1_gnt),
    .m1_rvalid (m1_rvalid),
    .m1_rdata  (m1_rdata),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .mem_rdata (mem_rdata)
  );

  function automatic logic [DATA_W-1:0] init_val(int i);
    if (i == 16) return 16'hBEEF;
    return DATA_W'(i * 16'h0105) ^ 16'hA5A5;
  endfunction

  // Stand-in for memController: synchronous RAM, READ_LAT cycles of read latency.
  logic [DATA_W-1:0] ram [256];
  logic [DATA_W-1:0] rd_line [READ_LAT];
  logic ram_loaded = 1'b0;
  always @(posedge clk) begin
    if (!ram_loaded) begin
      for (int i = 0; i < 256; i++) ram[i] <= init_val(i);
      ram_loaded <= 1'b1;
    end else begin
      if (mem_we) ram[mem_addr[7:0]] <= mem_wdata;
      rd_line[0] <= ram[mem_addr[7:0]];
    end
    for (int i = 1; i < READ_LAT; i++) rd_line[i] <= rd_line[i-1];
  end
  assign mem_rdata = rd_line[READ_LAT-1];

  // Reference model: owner is -1 (none), 0 or 1.
  typedef struct {int due; int id; logic [DATA_W-1:0] data;} rd_t;
  int own_m, last_m, cnt_m, cyc;
  logic [DATA_W-1:0] shadow [256];
  logic [DATA_W-1:0] lrd [2];
  rd_t rq[$];
  bit acc_last [2];
  int wait_c [2];
  bit wait_chk = 1'b0;
  bit chk_en = 1'b0;
  int checks = 0, failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%h expected=%h", name, cyc, act, want);
    end
  endtask

  task automatic model_reset();
    own_m = -1; last_m = 1; cnt_m = 0;
    rq.delete();
    for (int x = 0; x < 2; x++) begin
      lrd[x] = '0; acc_last[x] = 1'b0; wait_c[x] = 0;
    end
  endtask

  task automatic advance();
    int nxt;
    bit a [2];
    if (reset) begin
      model_reset();
      cyc++;
      return;
    end
    for (int x = 0; x < 2; x++) begin
      a[x] = (own_m == x) && req[x];
      if (a[x]) begin
        if (we[x]) shadow[addr[x][7:0]] = wdata[x];
        else rq.push_back('{due: cyc + READ_LAT, id: x, data: shadow[addr[x][7:0]]});
        if (wait_chk) chk("wait_bound", 32'(wait_c[x] <= MAX_BURST + 1), 32'd1);
        wait_c[x] = 0;
      end else if (req[x]) wait_c[x]++;
      else wait_c[x] = 0;
    end
    while (rq.size() > 0 && rq[0].due == cyc) begin
      lrd[rq[0].id] = rq[0].data;
      void'(rq.pop_front());
    end
    if (!enable) nxt = -1;
    else if (own_m >= 0) begin
      if (req[own_m] && (!req[1-own_m] || cnt_m + 1 < MAX_BURST)) nxt = own_m;
      else if (req[1-own_m]) nxt = 1 - own_m;
      else nxt = -1;
    end else if (req[0] && req[1]) nxt = 1 - last_m;
    else if (req[0]) nxt = 0;
    else if (req[1]) nxt = 1;
    else nxt = -1;
    if (nxt != own_m) cnt_m = 0;
    else if (own_m >= 0 && a[own_m]) cnt_m++;
    if (nxt >= 0) last_m = nxt;
    own_m = nxt;
    acc_last = a;
    cyc++;
  endtask

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin : cmp
    logic e_rv [2];
    logic [DATA_W-1:0] e_rd [2];
    logic a0, a1;
    if (chk_en && !reset) begin
      e_rv[0] = 1'b0; e_rv[1] = 1'b0;
      e_rd[0] = lrd[0]; e_rd[1] = lrd[1];
      foreach (rq[k]) if (rq[k].due == cyc) begin
        e_rv[rq[k].id] = 1'b1;
        e_rd[rq[k].id] = rq[k].data;
      end
      a0 = (own_m == 0) && req[0];
      a1 = (own_m == 1) && req[1];
      chk("m0_gnt", 32'(m0_gnt), 32'(own_m == 0));
      chk("m1_gnt", 32'(m1_gnt), 32'(own_m == 1));
      chk("mem_we", 32'(mem_we), 32'((a0 && we[0]) || (a1 && we[1])));
      chk("mem_addr", 32'(mem_addr), 32'((own_m == 1) ? addr[1] : addr[0]));
      chk("mem_wdata", 32'(mem_wdata), 32'((own_m == 1) ? wdata[1] : wdata[0]));
      chk("m0_rvalid", 32'(m0_rvalid), 32'(e_rv[0]));
      chk("m1_rvalid", 32'(m1_rvalid), 32'(e_rv[1]));
      chk("m0_rdata", 32'(m0_rdata), 32'(e_rd[0]));
      chk("m1_rdata", 32'(m1_rdata), 32'(e_rd[1]));
    end
  end

  task automatic step();
    @(posedge clk);
    advance();
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req = '0;
    model_reset();
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic rand_drive(input int p0, input int p1);
    for (int x = 0; x < 2; x++) begin
      if (!req[x] || acc_last[x]) begin
        req[x]   = ($urandom_range(0, 99) < ((x == 0) ? p0 : p1));
        we[x]    = 1'($urandom_range(0, 1));
        addr[x]  = ADDR_W'($urandom);
        wdata[x] = DATA_W'($urandom);
      end
    end
  endtask

  initial begin
    int cnt, g_cnt, rv_cnt, n_acc, p0, p1;
    int probs [4];
    probs[0] = 10; probs[1] = 50; probs[2] = 90; probs[3] = 100;
    for (int i = 0; i < 256; i++) shadow[i] = init_val(i);
    cyc = 0;
    reset = 1'b1; enable = 1'b1; req = '0; we = '0;
    addr[0] = '0; addr[1] = '0; wdata[0] = '0; wdata[1] = '0;
    model_reset();
    chk_en = 1'b1;
    repeat (3) step();
    reset = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_gnt", 32'({m0_gnt, m1_gnt}), 32'd0);
    chk("rst_rvalid", 32'({m0_rvalid, m1_rvalid}), 32'd0);
    chk("rst_rdata", 32'({m0_rdata, m1_rdata}), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    step();

    // Single read of 0x0010
    req[0] = 1'b1; we[0] = 1'b0; addr[0] = 15'h0010;
    @(negedge clk);
    chk("single_gnt_t", 32'(m0_gnt), 32'd0);
    step();
    @(negedge clk);
    chk("single_gnt_t1", 32'(m0_gnt), 32'd1);
    chk("single_addr", 32'(mem_addr), 32'h0010);
    step();
    req[0] = 1'b0;
    @(negedge clk);
    chk("single_rvalid", 32'(m0_rvalid), 32'd1);
    chk("single_rdata", 32'(m0_rdata), 32'hBEEF);
    chk("single_m1_rvalid", 32'(m1_rvalid), 32'd0);
    step();

    // Tie from reset: m0 first, m1 right after m0 drops
    do_reset();
    req = 2'b11; we = 2'b00; addr[0] = 15'h0001; addr[1] = 15'h0002;
    step();
    @(negedge clk);
    chk("tie_first_m0", 32'({m0_gnt, m1_gnt}), 32'b10);
    step();
    req[0] = 1'b0;
    step();
    @(negedge clk);
    chk("tie_then_m1", 32'({m0_gnt, m1_gnt}), 32'b01);
    step();
    req[1] = 1'b0;
    repeat (2) step();

    // Burst fairness: both stream writes
    do_reset();
    req = 2'b11; we = 2'b11;
    cnt = 0;
    for (int i = 0; i <= 32; i++) begin
      @(negedge clk);
      if (i >= 1) begin
        chk("burst_owner", 32'(m0_gnt), 32'((((i - 1) / MAX_BURST) % 2) == 0));
        cnt += int'(mem_we);
      end
      step();
      for (int x = 0; x < 2; x++) if (acc_last[x]) begin
        addr[x] = ADDR_W'($urandom); wdata[x] = DATA_W'($urandom);
      end
    end
    chk("burst_we_count", 32'(cnt), 32'd32);
    req = '0;
    repeat (3) step();

    // Lone streamer: m1 issues 20 reads
    req[1] = 1'b1; we[1] = 1'b0; addr[1] = 15'h0040;
    g_cnt = 0; rv_cnt = 0; n_acc = 0;
    for (int i = 0; i < 26; i++) begin
      @(negedge clk);
      if (i >= 1 && i <= 20) g_cnt += int'(m1_gnt);
      rv_cnt += int'(m1_rvalid);
      step();
      if (acc_last[1]) begin
        n_acc++;
        if (n_acc >= 20) req[1] = 1'b0;
        else addr[1] = ADDR_W'(15'h0040 + n_acc);
      end
    end
    chk("lone_gnt_cycles", 32'(g_cnt), 32'd20);
    chk("lone_rvalid_count", 32'(rv_cnt), 32'd20);

    // Reset with a read in flight
    req[0] = 1'b1; we[0] = 1'b0; addr[0] = 15'h0077;
    step();
    @(negedge clk);
    #1;
    reset = 1'b1;
    req = '0;
    model_reset();
    #1;
    chk("mrst_gnt", 32'({m0_gnt, m1_gnt}), 32'd0);
    chk("mrst_mem_we", 32'(mem_we), 32'd0);
    chk("mrst_rvalid", 32'({m0_rvalid, m1_rvalid}), 32'd0);
    cnt = 0;
    step();
    @(negedge clk);
    cnt += int'(m0_rvalid);
    step();
    reset = 1'b0;
    repeat (2) begin
      @(negedge clk);
      cnt += int'(m0_rvalid);
      step();
    end
    chk("mrst_squashed", 32'(cnt), 32'd0);

    // enable drops during an m0 tenure
    req[0] = 1'b1; we[0] = 1'b0; addr[0] = 15'h0020;
    step();
    enable = 1'b0;
    @(negedge clk);
    chk("en_gnt_before", 32'(m0_gnt), 32'd1);
    step();
    addr[0] = 15'h0021;
    req[1] = 1'b1; we[1] = 1'b0; addr[1] = 15'h0022;
    @(negedge clk);
    chk("en_gnt_dropped", 32'(m0_gnt), 32'd0);
    chk("en_rvalid", 32'(m0_rvalid), 32'd1);
    cnt = 0;
    repeat (4) begin
      step();
      @(negedge clk);
      cnt += int'(m0_gnt) + int'(m1_gnt);
    end
    chk("en_no_grants", 32'(cnt), 32'd0);
    step();
    enable = 1'b1;
    @(negedge clk);
    chk("en_first_cycle", 32'({m0_gnt, m1_gnt}), 32'd0);
    step();
    @(negedge clk);
    chk("en_resume_rr", 32'({m0_gnt, m1_gnt}), 32'b01);
    step();
    req = '0;
    repeat (3) step();

    // Random traffic, enable held high, starvation bound checked
    do_reset();
    wait_chk = 1'b1;
    for (int blk = 0; blk < 15; blk++) begin
      p0 = probs[$urandom_range(0, 3)];
      p1 = probs[$urandom_range(0, 3)];
      repeat (200) begin
        rand_drive(p0, p1);
        step();
      end
    end
    wait_chk = 1'b0;

    // Random traffic with enable toggling
    for (int blk = 0; blk < 8; blk++) begin
      p0 = probs[$urandom_range(0, 3)];
      p1 = probs[$urandom_range(0, 3)];
      repeat (200) begin
        rand_drive(p0, p1);
        enable = ($urandom_range(0, 9) != 0);
        step();
      end
    end
    enable = 1'b1;
    req = '0;
    repeat (5) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter that shares the single data port of `memController` between the CPU data path (requester 0) and a second bus master (requester 1, e.g. DMA/blitter/loader). It issues at most one access per cycle, grants bus ownership in bursts with round-robin fairness, and routes read data back to the issuing requester after a fixed memory read latency. It sits in `computer` between the masters and `memController`'s `addr/data/we/data_out` port; the VGA and instruction ports are untouched.

## Interface

- `ADDR_W`, 15, address width (matches `memController` data port)
- `DATA_W`, 16, data width
- `READ_LAT`, 1, cycles from issued read to valid `mem_rdata` (≥1)
- `MAX_BURST`, 8, max consecutive accepted accesses per tenure when the other requester is waiting (≥1)

- `clk`  in  1  system clock (output of `clkBuffer`)
- `reset`  in  1  asynchronous, active-high reset
- `enable`  in  1  global enable; low blocks new grants
- `m0_req`, `m1_req`  in  1  access request
- `m0_we`, `m1_we`  in  1  1 = write, 0 = read
- `m0_addr`, `m1_addr`  in  ADDR_W  access address
- `m0_wdata`, `m1_wdata`  in  DATA_W  write data
- `m0_gnt`, `m1_gnt`  out  1  registered grant; access accepted in any cycle with `req && gnt`
- `m0_rvalid`, `m1_rvalid`  out  1  one-cycle read-data strobe
- `m0_rdata`, `m1_rdata`  out  DATA_W  read data, valid with `rvalid`
- `mem_addr`  out  ADDR_W  to `memController` `addr`
- `mem_wdata`  out  DATA_W  to `memController` `data`
- `mem_we`  out  1  to `memController` `we`
- `mem_rdata`  in  DATA_W  from `memController` `data_out`

## Operation

- Owner state: `OWN_NONE`, `OWN_0`, `OWN_1`; `mX_gnt` = (owner == X), registered.
- Accept: cycle where `mX_gnt && mX_req`. `mem_addr/mem_wdata/mem_we` are muxed combinationally from the owner; `mem_we = accept && mX_we`, else 0. With no owner, `mem_addr`/`mem_wdata` follow requester 0 and `mem_we` = 0.
- Requester holds `req`, `we`, `addr`, `wdata` stable until accepted; after accept, it may present the next access in the following cycle.
- `burst_cnt` counts accepts in the current tenure; cleared on every owner change.
- Next owner, evaluated each edge:
  - `enable` = 0 → `OWN_NONE`.
  - Owner X requesting, other idle → stay X (no burst limit).
  - Owner X requesting, other requesting, `burst_cnt` (incl. this accept) < MAX_BURST → stay X; reaching MAX_BURST → switch to other.
  - Owner X not requesting → other if requesting, else `OWN_NONE`.
  - `OWN_NONE`: single requester wins; both → requester ≠ `last_owner`.
- `last_owner` resets so that requester 0 wins the first tie.
- Reads: each read accept pushes (valid, id) into a READ_LAT-deep tag pipe; at its output, `mID_rvalid` = 1 and `mID_rdata` <= `mem_rdata`. `rdata` holds its last value otherwise.
- `enable` falling: in-flight reads still complete; no further grants.
- Reset (any time): owner `OWN_NONE`, `last_owner` = 1, `burst_cnt` = 0, tag pipe cleared (in-flight reads squashed), all `gnt`/`rvalid` = 0, `rdata` = 0.

## Timing

- Idle bus, `req` rises in cycle t → `gnt` high in t+1, access issued in t+1, read `rvalid` in t+1+READ_LAT.
- Owner sustains one access per cycle.
- Owner switch costs zero dead cycles: new owner's `gnt` is high in the cycle after the old owner's last accept.
- Worst-case wait with the other requester streaming: MAX_BURST + 1 cycles.

## Structure

- Package `mem_arb_pkg`: owner enum (`OWN_NONE`, `OWN_0`, `OWN_1`) and requester-id type.
- Sub-module `read_tag_pipe`: READ_LAT-stage shift register of {valid, id}, async reset.
- Top holds owner FSM, burst counter, round-robin bit, and muxes.

## Test plan

- Single read: m0 read addr 0x0010, mem returns 0xBEEF → `m0_gnt` at t+1, `m0_rvalid` with 0xBEEF at t+2; `m1_rvalid` stays 0.
- Tie from reset: both `req` in the same cycle → m0 granted first; after m0 drops `req`, m1 granted the next cycle with no idle cycle.
- Burst fairness (MAX_BURST = 8): both stream writes → exactly 8 consecutive `mem_we` from m0, then 8 from m1, alternating; no cycle without `mem_we`.
- Lone streamer: only m1 requests 20 reads → `m1_gnt` held for all 20 cycles, 20 `rvalid` in order.
- Mid-burst reset: assert `reset` with 1 read in flight → `gnt`, `rvalid`, `mem_we` are 0 immediately, and the squashed read never produces `rvalid`.
- `enable` low during an m0 tenure → `m0_gnt` drops at the next edge, the pending read's `rvalid` still arrives, and no grants occur until `enable` returns high.
